// File: rtl/seven_seg_scanner.sv
// Four-digit seven-segment scanner for the Basys 3 common-anode display.
// The divided scan clock is sampled as data in the 100 MHz domain. Each
// rising edge advances the digit, with optional anti-ghost blanking between
// digits. The value is latched once per frame so that frames never tear.
module seven_seg_scanner #(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        clock_100MHz,
  input  logic        reset_n,
  input  logic        scan_clock,
  input  logic [15:0] value,
  input  logic [3:0]  digit_enable,
  input  logic [3:0]  dp_enable,
  input  logic        blank_leading_zeros,
  output logic [3:0]  anode,
  output logic [6:0]  segment,
  output logic        dp,
  output logic [1:0]  digit_index
);

  localparam int unsigned CNT_W = (BLANK_CYCLES == 0) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES);

  logic             sync1_q, sync2_q, sync3_q;
  logic             scan_tick_c;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             started_q, started_d;
  logic [CNT_W-1:0] blank_q, blank_d;
  logic [3:0]       anode_q, anode_d;
  logic [6:0]       segment_q, segment_d;
  logic             dp_q, dp_d;
  logic [3:0]       nibble_c;
  logic             suppress_c;
  logic             lit_c;

  // Hex nibble to active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // One-cycle strobe on a rising edge of the synchronized scan clock
  assign scan_tick_c = sync2_q & ~sync3_q;

  // Scan state: digit index, per-frame shadow latch, blanking countdown
  always_comb begin
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    started_d = started_q;
    blank_d   = blank_q;
    if (scan_tick_c) begin
      idx_d     = idx_q + 2'd1;
      // Latch at frame wrap, or on the very first tick after reset
      if ((idx_q == 2'd3) || !started_q) begin
        shadow_d = value;
      end
      started_d = 1'b1;
      blank_d   = BLANK_LOAD;
    end else if (blank_q != '0) begin
      blank_d = blank_q - CNT_W'(1);
    end
  end

  // Output decode from next state so pins update in the same cycle as the state
  always_comb begin
    nibble_c   = shadow_d[{idx_d, 2'b00} +: 4];
    suppress_c = 1'b0;
    case (idx_d)
      2'd1:    suppress_c = blank_leading_zeros && (shadow_d[15:4] == 12'h000);
      2'd2:    suppress_c = blank_leading_zeros && (shadow_d[15:8] == 8'h00);
      2'd3:    suppress_c = blank_leading_zeros && (shadow_d[15:12] == 4'h0);
      default: suppress_c = 1'b0;
    endcase
    lit_c     = started_d && (blank_d == '0) && digit_enable[idx_d] && !suppress_c;
    anode_d   = 4'hF;
    segment_d = 7'h7F;
    dp_d      = 1'b1;
    if (lit_c) begin
      anode_d   = ~(4'b0001 << idx_d);
      segment_d = seg_decode(nibble_c);
      dp_d      = ~dp_enable[idx_d];
    end
  end

  // State and output registers
  always_ff @(posedge clock_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      idx_q     <= 2'd0;
      shadow_q  <= 16'h0000;
      started_q <= 1'b0;
      blank_q   <= '0;
      anode_q   <= 4'hF;
      segment_q <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      sync1_q   <= scan_clock;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      started_q <= started_d;
      blank_q   <= blank_d;
      anode_q   <= anode_d;
      segment_q <= segment_d;
      dp_q      <= dp_d;
    end
  end

  assign anode       = anode_q;
  assign segment     = segment_q;
  assign dp          = dp_q;
  assign digit_index = idx_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized bench for seven_seg_scanner against a frame-level reference model.
module tb_seven_seg_scanner;

  localparam int unsigned BLANK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_clock = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  digit_enable = 4'hF;
  logic [3:0]  dp_enable = 4'h0;
  logic        blz = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        dp;
  logic [1:0]  digit_index;

  int n_tests = 0;
  int n_fail  = 0;

  seven_seg_scanner #(.BLANK_CYCLES(BLANK)) dut (
    .clock_100MHz       (clk),
    .reset_n            (rst_n),
    .scan_clock         (scan_clock),
    .value              (value),
    .digit_enable       (digit_enable),
    .dp_enable          (dp_enable),
    .blank_leading_zeros(blz),
    .anode              (anode),
    .segment            (segment),
    .dp                 (dp),
    .digit_index        (digit_index)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] anode_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  // Reference model: posedge count, queue of posedges at which a scan edge takes effect
  int          cyc = 0;
  int          eff_q[$];
  int          last_eff = 0;
  bit          started = 1'b0;
  int          midx = 0;
  logic [15:0] msh = 16'h0000;
  logic [3:0]  exp_anode = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1;
  logic [1:0]  exp_idx = 2'd0;

  // Capture of lit digits in the first frame
  bit          cap_en = 1'b0;
  logic [3:0]  last_cap = 4'hF;
  logic [3:0]  cap_a[$];
  logic [6:0]  cap_s[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_step();
    int hi;
    if (!rst_n) begin
      cyc = 0;
      eff_q.delete();
      started = 1'b0;
      midx = 0;
      msh = 16'h0000;
      last_eff = 0;
    end else begin
      cyc++;
      if (eff_q.size() > 0 && eff_q[0] == cyc) begin
        void'(eff_q.pop_front());
        if (midx == 3 || !started) msh = value;
        midx = (midx + 1) % 4;
        started = 1'b1;
        last_eff = cyc;
      end
    end
    hi = int'(msh) >> (4 * midx);
    exp_idx   = 2'(midx);
    exp_anode = 4'hF;
    exp_seg   = 7'h7F;
    exp_dp    = 1'b1;
    if (started && (cyc - last_eff) >= int'(BLANK) && digit_enable[midx] &&
        !(blz && midx != 0 && hi == 0)) begin
      exp_anode = anode_tab[midx];
      exp_seg   = seg_tab[hi & 15];
      exp_dp    = ~dp_enable[midx];
    end
  endtask

  task automatic sample_step();
    chk("anode", 16'(anode), 16'(exp_anode));
    chk("segment", 16'(segment), 16'(exp_seg));
    chk("dp", 16'(dp), 16'(exp_dp));
    chk("digit_index", 16'(digit_index), 16'(exp_idx));
    chk("one_anode", 16'($countones(~anode) <= 1), 16'd1);
    if (cap_en && anode != 4'hF && anode != last_cap) begin
      cap_a.push_back(anode);
      cap_s.push_back(segment);
      last_cap = anode;
    end
  endtask

  always @(posedge clk or negedge rst_n) model_step();
  always @(negedge clk) sample_step();

  // One scan_clock period: high for h posedges, then low for l posedges
  task automatic scan_period(input int h, input int l);
    @(posedge clk);
    #1 scan_clock = 1'b1;
    eff_q.push_back(cyc + 3);
    repeat (h) @(posedge clk);
    #1 scan_clock = 1'b0;
    repeat (l) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_anode"}, 16'(anode), 16'hF);
    chk({tag, "_segment"}, 16'(segment), 16'h7F);
    chk({tag, "_dp"}, 16'(dp), 16'd1);
    chk({tag, "_index"}, 16'(digit_index), 16'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Static 12AF frame ordering
    value = 16'h12AF;
    cap_en = 1'b1;
    repeat (6) scan_period(20, 20);
    cap_en = 1'b0;
    chk("cap_count", 16'(cap_a.size() >= 4), 16'd1);
    if (cap_a.size() >= 4) begin
      chk("frame_a0", 16'(cap_a[0]), 16'hD);
      chk("frame_s0", 16'(cap_s[0]), 16'h08);
      chk("frame_a1", 16'(cap_a[1]), 16'hB);
      chk("frame_s1", 16'(cap_s[1]), 16'h24);
      chk("frame_a2", 16'(cap_a[2]), 16'h7);
      chk("frame_s2", 16'(cap_s[2]), 16'h79);
      chk("frame_a3", 16'(cap_a[3]), 16'hE);
      chk("frame_s3", 16'(cap_s[3]), 16'h0E);
    end

    // Leading-zero suppression on and off
    value = 16'h0005;
    blz = 1'b1;
    repeat (8) scan_period(20, 20);
    blz = 1'b0;
    repeat (8) scan_period(20, 20);

    // Mid-frame value change must wait for the wrap
    value = 16'h1111;
    for (int i = 0; i < 8; i++) begin
      scan_period(15, 15);
      if (digit_index == 2'd1) break;
    end
    value = 16'h2222;
    repeat (8) scan_period(15, 15);

    // Disabled digit with its decimal point requested
    dp_enable = 4'b0100;
    digit_enable = 4'b1011;
    repeat (8) scan_period(20, 20);

    // Randomized inputs and scan periods, including out-of-spec fast scanning
    for (int i = 0; i < 40; i++) begin
      value = 16'($urandom) >> $urandom_range(0, 15);
      digit_enable = 4'($urandom);
      dp_enable = 4'($urandom);
      blz = 1'($urandom);
      scan_period($urandom_range(2, 20), $urandom_range(2, 20));
    end

    // Reset pulsed in the middle of a blanking window
    digit_enable = 4'hF;
    blz = 1'b0;
    dp_enable = 4'h0;
    @(posedge clk);
    #1 scan_clock = 1'b1;
    eff_q.push_back(cyc + 3);
    repeat (2) @(posedge clk);
    #1 scan_clock = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("midblank_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    value = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1 scan_clock = 1'b1;
    eff_q.push_back(cyc + 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_reset_index", 16'(digit_index), 16'd1);
    chk("post_reset_blank", 16'(anode), 16'hF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_reset_anode", 16'(anode), 16'hD);
    chk("post_reset_segment", 16'(segment), 16'h06);
    #1 scan_clock = 1'b0;
    repeat (6) scan_period(20, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
